// File: rtl/fpga_pad_router.sv
// Run-time programmable router between Caravel GPIO pads and the FPGA fabric edge GPIOs.
// Optional fabric loopback is compiled in with `define PAD_ROUTER_LOOPBACK_EN.
module fpga_pad_router #(
  parameter int          NUM_PADS    = 38,
  parameter int          IO_NORTH    = 10,
  parameter int          IO_SOUTH    = 8,
  parameter int          IO_EAST     = 10,
  parameter int          IO_WEST     = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h3010_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                                         wb_clk_i,
  input  logic                                         wb_rst_ni,
  input  logic                                         wbs_stb_i,
  input  logic                                         wbs_cyc_i,
  input  logic                                         wbs_we_i,
  input  logic [3:0]                                   wbs_sel_i,
  input  logic [31:0]                                  wbs_dat_i,
  input  logic [31:0]                                  wbs_adr_i,
  output logic                                         wbs_ack_o,
  output logic [31:0]                                  wbs_dat_o,
  input  logic [NUM_PADS-1:0]                          io_in,
  output logic [NUM_PADS-1:0]                          io_out,
  output logic [NUM_PADS-1:0]                          io_oeb,
  output logic [IO_NORTH+IO_SOUTH+IO_EAST+IO_WEST-1:0] fab_in,
  input  logic [IO_NORTH+IO_SOUTH+IO_EAST+IO_WEST-1:0] fab_out
);

  localparam int F = IO_NORTH + IO_SOUTH + IO_EAST + IO_WEST;

  // Handshake: a request is stb & cyc while ack is low; ack rises on the next
  // edge for exactly one cycle, carrying read data, and register side effects
  // land on that same edge. Every address is acked, mapped or not.
  logic       req;
  logic       win_hit;
  logic [5:0] pad_word;
  logic       pad_hit;
  logic       ctrl_hit;
  logic       stat_hit;
  logic       wr_pad;
  logic       wr_ctrl;
  logic       do_apply;

  logic [9:0] shadow_q [NUM_PADS];
  logic [9:0] active_q [NUM_PADS];
  logic       lock_q;
  logic       lb_en;
  logic       pending;
  logic [31:0] rdata;

  logic [NUM_PADS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PADS-1:0] sync_in;
  logic [NUM_PADS-1:0] route_out;
  logic [NUM_PADS-1:0] route_in;
  logic [F-1:0]        fab_route;

  logic unused_ok;
  assign unused_ok = ^{wbs_adr_i[1:0], wbs_dat_i[31:10], wbs_dat_i[7:2], wbs_sel_i[3:2]};

  assign req      = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign win_hit  = (wbs_adr_i[31:9] == BASE_ADDR[31:9]);
  assign pad_word = wbs_adr_i[7:2];
  assign pad_hit  = win_hit & ~wbs_adr_i[8] & (32'(pad_word) < NUM_PADS);
  assign ctrl_hit = win_hit & (wbs_adr_i[8:2] == 7'h40);
  assign stat_hit = win_hit & (wbs_adr_i[8:2] == 7'h41);

  assign wr_pad   = req & wbs_we_i & pad_hit & ~lock_q;
  assign wr_ctrl  = req & wbs_we_i & ctrl_hit & wbs_sel_i[0];
  // The lock state before this write decides; a lock set by the same write only gates later ones.
  assign do_apply = wr_ctrl & wbs_dat_i[1] & ~lock_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        shadow_q[p] <= '0;
        active_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PADS; p++) begin
        if (wr_pad && (pad_word == 6'(p))) begin
          if (wbs_sel_i[0]) shadow_q[p][7:0] <= wbs_dat_i[7:0];
          if (wbs_sel_i[1]) shadow_q[p][9:8] <= wbs_dat_i[9:8];
        end
        if (do_apply) active_q[p] <= shadow_q[p];
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      lock_q <= 1'b0;
    end else if (wr_ctrl && wbs_dat_i[0]) begin
      lock_q <= 1'b1;
    end
  end

`ifdef PAD_ROUTER_LOOPBACK_EN
  logic         lb_en_q;
  logic [F-1:0] lb_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      lb_en_q <= 1'b0;
      lb_q    <= '0;
    end else begin
      if (wr_ctrl && !lock_q) lb_en_q <= wbs_dat_i[2];
      lb_q <= fab_out;
    end
  end

  assign lb_en  = lb_en_q;
  assign fab_in = lb_en_q ? lb_q : fab_route;
`else
  assign lb_en  = 1'b0;
  assign fab_in = fab_route;
`endif

  always_comb begin
    pending = 1'b0;
    for (int p = 0; p < NUM_PADS; p++) begin
      if (shadow_q[p] != active_q[p]) pending = 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    if (pad_hit) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        if (pad_word == 6'(p)) rdata[9:0] = shadow_q[p];
      end
    end else if (ctrl_hit) begin
      rdata = {29'd0, lb_en, 1'b0, lock_q};
    end else if (stat_hit) begin
      rdata = {15'd0, pending, 8'(NUM_PADS), 8'(F)};
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req && !wbs_we_i) ? rdata : 32'd0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= io_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  // An index at or beyond F never routes, whatever EN says.
  always_comb begin
    route_out = '0;
    route_in  = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      if (active_q[p][9] && (active_q[p][7:0] < 8'(F))) begin
        route_out[p] = active_q[p][8];
        route_in[p]  = ~active_q[p][8];
      end
    end
  end

  always_comb begin
    io_out = '0;
    io_oeb = '1;
    for (int p = 0; p < NUM_PADS; p++) begin
      if (route_out[p] && !lb_en) begin
        io_oeb[p] = 1'b0;
        for (int i = 0; i < F; i++) begin
          if (active_q[p][7:0] == 8'(i)) io_out[p] = fab_out[i];
        end
      end
    end
  end

  // Scan pads high to low so the lowest-numbered claimant is the last writer and wins.
  always_comb begin
    fab_route = '0;
    for (int i = 0; i < F; i++) begin
      for (int p = NUM_PADS - 1; p >= 0; p--) begin
        if (route_in[p] && (active_q[p][7:0] == 8'(i))) fab_route[i] = sync_in[p];
      end
    end
  end

endmodule

// File: tb/tb_fpga_pad_router.sv
// Bench for fpga_pad_router: register table, directed corner sequences and a
// randomized run against a pad-routing reference model.
module tb_fpga_pad_router;

  localparam int          NP   = 38;
  localparam int          F    = 38;
  localparam logic [31:0] BASE = 32'h3010_0000;

  logic          clk;
  logic          rst_n;
  logic          wbs_stb_i;
  logic          wbs_cyc_i;
  logic          wbs_we_i;
  logic [3:0]    wbs_sel_i;
  logic [31:0]   wbs_dat_i;
  logic [31:0]   wbs_adr_i;
  logic          wbs_ack_o;
  logic [31:0]   wbs_dat_o;
  logic [NP-1:0] io_in;
  logic [NP-1:0] io_out;
  logic [NP-1:0] io_oeb;
  logic [F-1:0]  fab_in;
  logic [F-1:0]  fab_out;

  int n_cmp;
  int n_fail;

  // Reference model state
  logic [9:0] m_shadow [NP];
  logic [9:0] m_active [NP];
  logic       m_lock;
  logic       m_lb;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[20];

  fpga_pad_router dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wbs_stb_i(wbs_stb_i),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_we_i (wbs_we_i),
    .wbs_sel_i(wbs_sel_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_ack_o(wbs_ack_o),
    .wbs_dat_o(wbs_dat_o),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .fab_in   (fab_in),
    .fab_out  (fab_out)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_shadow[p] = '0;
      m_active[p] = '0;
    end
    m_lock = 1'b0;
    m_lb   = 1'b0;
  endtask

  task automatic model_write(input logic [31:0] a, input logic [3:0] sel, input logic [31:0] d);
    logic [31:0] off;
    if (a < BASE || a >= BASE + 32'd512) return;
    off = a - BASE;
    if (off < NP * 4) begin
      if (!m_lock) begin
        if (sel[0]) m_shadow[off / 4][7:0] = d[7:0];
        if (sel[1]) m_shadow[off / 4][9:8] = d[9:8];
      end
    end else if (off / 4 == 64 && sel[0]) begin
      if (!m_lock) begin
        if (d[1]) for (int p = 0; p < NP; p++) m_active[p] = m_shadow[p];
`ifdef PAD_ROUTER_LOOPBACK_EN
        m_lb = d[2];
`endif
      end
      if (d[0]) m_lock = 1'b1;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] off;
    logic        pend;
    if (a < BASE || a >= BASE + 32'd512) return 32'd0;
    off = a - BASE;
    if (off < NP * 4) return {22'd0, m_shadow[off / 4]};
    if (off / 4 == 64) return {29'd0, m_lb, 1'b0, m_lock};
    if (off / 4 == 65) begin
      pend = 1'b0;
      for (int p = 0; p < NP; p++) if (m_shadow[p] != m_active[p]) pend = 1'b1;
      return (pend ? 32'h1_0000 : 32'h0) + NP * 256 + F;
    end
    return 32'd0;
  endfunction

  function automatic logic [NP-1:0] exp_oeb();
    logic [NP-1:0] r = '1;
    if (m_lb) return r;
    for (int p = 0; p < NP; p++)
      if (m_active[p][9] && m_active[p][8] && int'(m_active[p][7:0]) < F) r[p] = 1'b0;
    return r;
  endfunction

  function automatic logic [NP-1:0] exp_out();
    logic [NP-1:0] r = '0;
    logic [F-1:0]  sh;
    if (m_lb) return r;
    for (int p = 0; p < NP; p++) begin
      if (m_active[p][9] && m_active[p][8] && int'(m_active[p][7:0]) < F) begin
        sh   = fab_out >> m_active[p][7:0];
        r[p] = sh[0];
      end
    end
    return r;
  endfunction

  // Assumes io_in and fab_out have been stable long enough to pass the pipeline.
  function automatic logic [F-1:0] exp_fab_in();
    logic [F-1:0] r = '0;
    if (m_lb) return fab_out;
    for (int i = 0; i < F; i++) begin
      for (int p = 0; p < NP; p++) begin
        if (m_active[p][9] && !m_active[p][8] && int'(m_active[p][7:0]) == i) begin
          r[i] = io_in[p];
          break;
        end
      end
    end
    return r;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".io_oeb"}, 64'(io_oeb), 64'(exp_oeb()));
    chk({tag, ".io_out"}, 64'(io_out), 64'(exp_out()));
    chk({tag, ".fab_in"}, 64'(fab_in), 64'(exp_fab_in()));
  endtask

  // Driver: called #1 after a rising edge, returns #1 after the edge following ack.
  task automatic wb_xfer(input logic [31:0] a, input logic we, input logic [3:0] sel,
                         input logic [31:0] d, output logic [31:0] rd);
    int n;
    wbs_adr_i = a;
    wbs_we_i  = we;
    wbs_sel_i = sel;
    wbs_dat_i = d;
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!wbs_ack_o && n < 16);
    rd = wbs_dat_o;
    n_cmp++;
    if (!wbs_ack_o) begin
      n_fail++;
      $display("FAIL wb_ack: addr %h got no ack within 16 cycles, expected ack", a);
    end
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_we_i  = 1'b0;
    if (we) model_write(a, sel, d);
    @(posedge clk);
    #1;
  endtask

  task automatic wb_wr(input logic [31:0] a, input logic [3:0] sel, input logic [31:0] d);
    logic [31:0] rd;
    wb_xfer(a, 1'b1, sel, d, rd);
  endtask

  task automatic wb_rd_chk(input string nm, input logic [31:0] a);
    logic [31:0] rd;
    wb_xfer(a, 1'b0, 4'hF, 32'd0, rd);
    chk(nm, 64'(rd), 64'(model_read(a)));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic [63:0] r64;
    int          p;
    int          idx;
    n_cmp  = 0;
    n_fail = 0;
    model_reset();

    tbl[0]  = '{BASE + 32'h000, 1'b0, 4'hF, 32'h0,        32'h0};
    tbl[1]  = '{BASE + 32'h094, 1'b0, 4'hF, 32'h0,        32'h0};
    tbl[2]  = '{BASE + 32'h100, 1'b0, 4'hF, 32'h0,        32'h0};
    tbl[3]  = '{BASE + 32'h104, 1'b0, 4'hF, 32'h0,        32'h0000_2626};
    tbl[4]  = '{BASE + 32'h098, 1'b0, 4'hF, 32'h0,        32'h0};
    tbl[5]  = '{BASE + 32'h008, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0};
    tbl[6]  = '{BASE + 32'h008, 1'b0, 4'hF, 32'h0,        32'h0000_03FF};
    tbl[7]  = '{BASE + 32'h104, 1'b0, 4'hF, 32'h0,        32'h0001_2626};
    tbl[8]  = '{BASE + 32'h008, 1'b1, 4'h1, 32'h0000_0012, 32'h0};
    tbl[9]  = '{BASE + 32'h008, 1'b0, 4'hF, 32'h0,        32'h0000_0312};
    tbl[10] = '{BASE + 32'h008, 1'b1, 4'h2, 32'h0,        32'h0};
    tbl[11] = '{BASE + 32'h008, 1'b0, 4'hF, 32'h0,        32'h0000_0012};
    tbl[12] = '{BASE + 32'h008, 1'b1, 4'h0, 32'h0000_03FF, 32'h0};
    tbl[13] = '{BASE + 32'h008, 1'b0, 4'hF, 32'h0,        32'h0000_0012};
    tbl[14] = '{BASE + 32'h098, 1'b1, 4'hF, 32'h0000_03FF, 32'h0};
    tbl[15] = '{BASE + 32'h098, 1'b0, 4'hF, 32'h0,        32'h0};
    tbl[16] = '{BASE + 32'h200, 1'b0, 4'hF, 32'h0,        32'h0};
    tbl[17] = '{32'h3000_0008,  1'b0, 4'hF, 32'h0,        32'h0};
    tbl[18] = '{BASE + 32'h008, 1'b1, 4'hF, 32'h0,        32'h0};
    tbl[19] = '{BASE + 32'h104, 1'b0, 4'hF, 32'h0,        32'h0000_2626};

    rst_n     = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'h0;
    wbs_dat_i = '0;
    wbs_adr_i = '0;
    r64       = {$urandom(), $urandom()};
    io_in     = r64[NP-1:0];
    r64       = {$urandom(), $urandom()};
    fab_out   = r64[F-1:0];

    // Reset state, with live pad and fabric activity held off
    cycles(3);
    chk("rst.io_oeb", 64'(io_oeb), {64{1'b1}} >> (64 - NP));
    chk("rst.io_out", 64'(io_out), 64'd0);
    chk("rst.fab_in", 64'(fab_in), 64'd0);
    chk("rst.ack", 64'(wbs_ack_o), 64'd0);
    chk("rst.dat", 64'(wbs_dat_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    io_in   = '0;
    fab_out = '0;
    cycles(2);

    // Register table
    for (int k = 0; k < 20; k++) begin
      wb_xfer(tbl[k].addr, tbl[k].we, tbl[k].sel, tbl[k].wdata, rd);
      if (!tbl[k].we) chk($sformatf("tbl%0d", k), 64'(rd), 64'(tbl[k].exp));
    end

    // Shadow write has no effect until apply; output follows fab_out combinationally
    wb_wr(BASE + 32'h014, 4'hF, 32'h300);
    chk("t2.oeb5_pre", 64'(io_oeb[5]), 64'd1);
    wb_rd_chk("t2.status_pend", BASE + 32'h104);
    wb_wr(BASE + 32'h100, 4'hF, 32'h2);
    chk("t2.oeb5_post", 64'(io_oeb[5]), 64'd0);
    fab_out[0] = 1'b1;
    #1;
    chk("t2.out5_hi", 64'(io_out[5]), 64'd1);
    fab_out[0] = 1'b0;
    #1;
    chk("t2.out5_lo", 64'(io_out[5]), 64'd0);
    wb_rd_chk("t2.status_clr", BASE + 32'h104);

    // Two pads claim fabric input 4: the lower pad wins, after two sync stages
    wb_wr(BASE + 32'h00C, 4'hF, 32'h204);
    wb_wr(BASE + 32'h01C, 4'hF, 32'h204);
    wb_wr(BASE + 32'h100, 4'hF, 32'h2);
    cycles(3);
    io_in[3] = 1'b1;
    cycles(1);
    chk("t3.lat1", 64'(fab_in[4]), 64'd0);
    cycles(1);
    chk("t3.lat2", 64'(fab_in[4]), 64'd1);
    io_in[3] = 1'b0;
    io_in[7] = 1'b1;
    cycles(3);
    chk("t3.pad7_ignored", 64'(fab_in[4]), 64'd0);
    check_all("t3");

    // Index beyond the fabric is unmapped
    wb_wr(BASE + 32'h024, 4'hF, 32'h3FF);
    wb_wr(BASE + 32'h100, 4'hF, 32'h2);
    chk("t4.oeb9", 64'(io_oeb[9]), 64'd1);
    wb_rd_chk("t4.rd200", BASE + 32'h200);

    // Randomized routing against the model
    for (int it = 0; it < 30; it++) begin
      for (int k = 0; k < 3; k++) begin
        p = int'($urandom_range(0, NP - 1));
        case ($urandom_range(0, 3))
          0:       idx = int'($urandom_range(F, 255));
          1:       idx = int'($urandom_range(0, F - 1));
          default: idx = int'($urandom_range(0, 5));
        endcase
        wb_wr(BASE + 32'(p * 4), ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF,
              {22'd0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'(idx)});
      end
      p = int'($urandom_range(0, NP - 1));
      wb_rd_chk($sformatf("rnd%0d.pad%0d", it, p), BASE + 32'(p * 4));
      if ($urandom_range(0, 1) == 1) wb_wr(BASE + 32'h100, 4'hF, 32'h2);
      r64     = {$urandom(), $urandom()};
      io_in   = r64[NP-1:0];
      r64     = {$urandom(), $urandom()};
      fab_out = r64[F-1:0];
      cycles(3);
      check_all($sformatf("rnd%0d", it));
      wb_rd_chk($sformatf("rnd%0d.status", it), BASE + 32'h104);
      r64     = {$urandom(), $urandom()};
      fab_out = r64[F-1:0];
      #1;
      chk($sformatf("rnd%0d.out_comb", it), 64'(io_out), 64'(exp_out()));
    end

`ifdef PAD_ROUTER_LOOPBACK_EN
    wb_wr(BASE + 32'h100, 4'hF, 32'h4);
    wb_rd_chk("t6.ctrl", BASE + 32'h100);
    fab_out = 38'h15;
    cycles(1);
    chk("t6.lb_fab_in", 64'(fab_in), 64'h15);
    chk("t6.lb_oeb", 64'(io_oeb), {64{1'b1}} >> (64 - NP));
    chk("t6.lb_out", 64'(io_out), 64'd0);
    wb_wr(BASE + 32'h100, 4'hF, 32'h0);
    cycles(3);
    check_all("t6.off");
`else
    wb_wr(BASE + 32'h100, 4'hF, 32'h4);
    wb_xfer(BASE + 32'h100, 1'b0, 4'hF, 32'd0, rd);
    chk("t6.ctrl_no_lb", 64'(rd), 64'h0);
`endif

    // Apply together with lock, then locked writes are acked but ignored
    wb_wr(BASE + 32'h000, 4'hF, 32'h205);
    wb_wr(BASE + 32'h100, 4'hF, 32'h3);
    wb_rd_chk("t5.ctrl", BASE + 32'h100);
    wb_wr(BASE + 32'h000, 4'hF, 32'h300);
    wb_wr(BASE + 32'h100, 4'hF, 32'h2);
    wb_xfer(BASE + 32'h000, 1'b0, 4'hF, 32'd0, rd);
    chk("t5.pad0_rb", 64'(rd), 64'h205);
    chk("t5.pad0_input", 64'(io_oeb[0]), 64'd1);
    cycles(3);
    check_all("t5");

    // Reset in the middle of a transfer drops it and clears the lock
    wbs_adr_i = BASE + 32'h104;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'hF;
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    #2;
    rst_n = 1'b0;
    cycles(1);
    chk("rst2.ack", 64'(wbs_ack_o), 64'd0);
    chk("rst2.oeb", 64'(io_oeb), {64{1'b1}} >> (64 - NP));
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycles(3);
    wb_rd_chk("rst2.ctrl", BASE + 32'h100);
    wb_rd_chk("rst2.status", BASE + 32'h104);
    check_all("rst2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
